// File: rtl/seq_multiplier.sv
// seq_multiplier: sequential shift-add multiplier with a start/done handshake
// and a per-operation signed/unsigned mode.
//
// Ports:
//   clk          single clock, rising edge
//   rst          synchronous active-high reset
//   plicand      multiplicand, sampled when start is accepted
//   pliar        multiplier, sampled when start is accepted
//   signed_mode  1 = two's complement operands, 0 = unsigned (sampled with start)
//   start        level request, accepted only in IDLE
//   busy         high from the cycle after acceptance through the done cycle
//   done         one-cycle pulse, product valid from this cycle on
//   product      registered 2*WIDTH-bit result, held until the next done
//
// state  | meaning
// IDLE   | waiting for start, outputs idle
// RUN    | one shift-add iteration per cycle, WIDTH iterations
// FINISH | done pulse cycle, product already registered
module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   plicand,
  input  logic [WIDTH-1:0]   pliar,
  input  logic               signed_mode,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t             state;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;
  logic               neg;

  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] acc_sum;

  // Negating the most negative value wraps to 2^(WIDTH-1), which is the
  // correct magnitude when read as unsigned.
  always_comb begin
    mag_a = (signed_mode && plicand[WIDTH-1]) ? (~plicand + 1'b1) : plicand;
    mag_b = (signed_mode && pliar[WIDTH-1])   ? (~pliar + 1'b1)   : pliar;
  end

  assign acc_sum = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mcand  <= {{WIDTH{1'b0}}, mag_a};
            mplier <= mag_b;
            neg    <= signed_mode & (plicand[WIDTH-1] ^ pliar[WIDTH-1]);
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          acc    <= acc_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          // Product is registered on the last iteration so it is visible
          // together with done in the FINISH cycle.
          if (cnt == CW'(WIDTH - 1)) begin
            product <= neg ? (~acc_sum + 1'b1) : acc_sum;
            done    <= 1'b1;
            state   <= FINISH;
          end
        end
        FINISH: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
module tb_seq_multiplier;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic [7:0]  plicand8 = '0, pliar8 = '0;
  logic        smode8 = 1'b0, start8 = 1'b0;
  logic        busy8, done8;
  logic [15:0] product8;

  logic [3:0]  plicand4 = '0, pliar4 = '0;
  logic        smode4 = 1'b0, start4 = 1'b0;
  logic        busy4, done4;
  logic [7:0]  product4;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] q8[$];
  logic [7:0]  q4[$];

  always #5 clk = ~clk;

  seq_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .plicand(plicand8), .pliar(pliar8),
    .signed_mode(smode8), .start(start8), .busy(busy8), .done(done8),
    .product(product8)
  );

  seq_multiplier #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .plicand(plicand4), .pliar(pliar4),
    .signed_mode(smode4), .start(start4), .busy(busy4), .done(done4),
    .product(product4)
  );

  function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b,
                                         input logic s);
    longint x, y;
    x = s ? longint'($signed(a)) : longint'(a);
    y = s ? longint'($signed(b)) : longint'(b);
    return 16'(x * y);
  endfunction

  // Launch one WIDTH=8 operation, then wait for done and check latency,
  // busy framing and the scoreboard entry.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s,
                      input logic [15:0] exp, input string name);
    logic [15:0] e;
    bit seen;
    seen = 0;
    @(negedge clk);
    plicand8 = a; pliar8 = b; smode8 = s; start8 = 1'b1;
    q8.push_back(exp);
    @(posedge clk);
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(negedge clk);
      start8 = 1'b0;
      plicand8 = 8'h5A; pliar8 = 8'hC3; smode8 = ~s;
      if (k == 1) begin
        n_checks++;
        if (busy8 !== 1'b1) begin
          n_fail++; $display("FAIL %s busy_after_accept got %b want 1", name, busy8);
        end
      end
      if (done8 === 1'b1) begin
        seen = 1;
        n_checks++;
        if (k != 9) begin
          n_fail++; $display("FAIL %s latency got %0d want 9", name, k);
        end
        e = (q8.size() > 0) ? q8.pop_front() : 16'hxxxx;
        n_checks++;
        if (product8 !== e) begin
          n_fail++; $display("FAIL %s product got %h want %h", name, product8, e);
        end
        n_checks++;
        if (busy8 !== 1'b1) begin
          n_fail++; $display("FAIL %s busy_in_done got %b want 1", name, busy8);
        end
      end
    end
    if (!seen) begin
      n_checks++; n_fail++;
      $display("FAIL %s timeout got no_done want done", name);
    end
    @(negedge clk);
    n_checks++;
    if (done8 !== 1'b0 || busy8 !== 1'b0) begin
      n_fail++; $display("FAIL %s after_done got done=%b busy=%b want 0 0", name, done8, busy8);
    end
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic s,
                      input logic [7:0] exp, input string name);
    logic [7:0] e;
    bit seen;
    seen = 0;
    @(negedge clk);
    plicand4 = a; pliar4 = b; smode4 = s; start4 = 1'b1;
    q4.push_back(exp);
    @(posedge clk);
    for (int k = 1; k <= 12 && !seen; k++) begin
      @(negedge clk);
      start4 = 1'b0;
      if (done4 === 1'b1) begin
        seen = 1;
        n_checks++;
        if (k != 5) begin
          n_fail++; $display("FAIL %s latency got %0d want 5", name, k);
        end
        e = (q4.size() > 0) ? q4.pop_front() : 8'hxx;
        n_checks++;
        if (product4 !== e) begin
          n_fail++; $display("FAIL %s product got %h want %h", name, product4, e);
        end
      end
    end
    if (!seen) begin
      n_checks++; n_fail++;
      $display("FAIL %s timeout got no_done want done", name);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; start8 = 1'b1; start4 = 1'b1; plicand8 = 8'h11; pliar8 = 8'h22;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || product8 !== 16'h0) begin
      n_fail++; $display("FAIL reset8 got busy=%b done=%b product=%h want 0 0 0000", busy8, done8, product8);
    end
    n_checks++;
    if (busy4 !== 1'b0 || done4 !== 1'b0 || product4 !== 8'h0) begin
      n_fail++; $display("FAIL reset4 got busy=%b done=%b product=%h want 0 0 00", busy4, done4, product4);
    end
    rst = 1'b0; start8 = 1'b0; start4 = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy8 !== 1'b0) begin
      n_fail++; $display("FAIL reset_start_ignored got busy=%b want 0", busy8);
    end
  endtask

  task automatic test_unsigned();
    run8(8'hFF, 8'hFF, 1'b0, 16'hFE01, "u255x255");
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      n_checks++;
      if (product8 !== 16'hFE01 || done8 !== 1'b0) begin
        n_fail++; $display("FAIL hold cyc%0d got product=%h done=%b want fe01 0", k, product8, done8);
      end
    end
  endtask

  task automatic test_signed();
    run8(8'h80, 8'h80, 1'b1, 16'h4000, "s_m128xm128");
    run8(8'hFD, 8'h05, 1'b1, 16'hFFF1, "s_m3x5");
    run8(8'hF9, 8'h00, 1'b1, 16'h0000, "s_m7x0");
  endtask

  task automatic test_mode_bits();
    run8(8'h80, 8'h02, 1'b0, 16'h0100, "u80x02");
    run8(8'h80, 8'h02, 1'b1, 16'hFF00, "s80x02");
  endtask

  task automatic test_random();
    logic [7:0] a, b;
    logic s;
    for (int i = 0; i < 6; i++) begin
      a = 8'($urandom); b = 8'($urandom); s = 1'($urandom);
      run8(a, b, s, model8(a, b, s), "random");
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] e;
    @(negedge clk);
    plicand8 = 8'd10; pliar8 = 8'd20; smode8 = 1'b0; start8 = 1'b1;
    q8.push_back(model8(8'd10, 8'd20, 1'b0));
    @(posedge clk);
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (k == 3) begin
        plicand8 = 8'd3; pliar8 = 8'd4;
        q8.push_back(model8(8'd3, 8'd4, 1'b0));
      end
      if (k == 19) start8 = 1'b0;
      n_checks++;
      if (done8 !== ((k == 9) || (k == 19))) begin
        n_fail++; $display("FAIL b2b_done cyc%0d got %b want %b", k, done8, (k == 9) || (k == 19));
      end
      if (done8 === 1'b1) begin
        e = (q8.size() > 0) ? q8.pop_front() : 16'hxxxx;
        n_checks++;
        if (product8 !== e) begin
          n_fail++; $display("FAIL b2b_product cyc%0d got %h want %h", k, product8, e);
        end
      end
    end
    n_checks++;
    if (q8.size() != 0) begin
      n_fail++; $display("FAIL b2b_queue got %0d pending want 0", q8.size());
      q8.delete();
    end
  endtask

  task automatic test_reset_midop();
    @(negedge clk);
    plicand8 = 8'd200; pliar8 = 8'd100; smode8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      start8 = 1'b0;
      if (k == 4) rst = 1'b1;
      if (k == 5) begin
        n_checks++;
        if (busy8 !== 1'b0 || product8 !== 16'h0) begin
          n_fail++; $display("FAIL midrst got busy=%b product=%h want 0 0000", busy8, product8);
        end
        rst = 1'b0;
      end
      n_checks++;
      if (done8 !== 1'b0) begin
        n_fail++; $display("FAIL midrst_nodone cyc%0d got %b want 0", k, done8);
      end
      if (k == 5) k = 16;
    end
    @(negedge clk);
    run8(8'd13, 8'd11, 1'b0, 16'd143, "after_rst");
  endtask

  task automatic test_width4();
    run4(4'hF, 4'hF, 1'b0, 8'hE1, "w4_u15x15");
    run4(4'h8, 4'h7, 1'b1, 8'hC8, "w4_m8x7");
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_mode_bits();
    test_random();
    test_back_to_back();
    test_reset_midop();
    test_width4();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Parametrised sequential shift-add multiplier with a start/done handshake and a per-operation signed/unsigned mode, the next generation of the team's fixed 8x8 multiplier. It computes a full 2*WIDTH-bit product in a fixed WIDTH+1 cycles after start is accepted. The product is held stable for the display path (seg7) until the next result. It sits behind the push-button start detector and runs on the same clock as its consumers.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32; product is 2*WIDTH bits
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- plicand  input  WIDTH  multiplicand; sampled only on the cycle start is accepted
- pliar  input  WIDTH  multiplier; sampled only on the cycle start is accepted
- signed_mode  input  1  1 = operands are two's complement, 0 = unsigned; sampled with start
- start  input  1  level; accepted only in IDLE
- busy  output  1  high from the cycle after acceptance through the done cycle
- done  output  1  one-cycle pulse; product is valid from this cycle on
- product  output  2*WIDTH  registered result; held until the next done

## Operation
- States: IDLE, RUN, FINISH.
- IDLE: busy=0, done=0. When start=1, the block latches the operands and enters RUN.
  - Unsigned: it latches the raw operands.
  - Signed: it latches the magnitudes |plicand| and |pliar| as WIDTH-bit unsigned values, and latches neg = sign(plicand) XOR sign(pliar).
  - It clears the 2*WIDTH accumulator and sets the iteration counter to 0.
- RUN: one iteration per cycle.
  - If the multiplier register LSB=1, acc += mcand register (2*WIDTH wide, zero-extended).
  - The mcand register shifts left by 1; the multiplier register shifts right by 1; the counter increments.
  - After exactly WIDTH iterations (counter reaches WIDTH-1 on the last one), the block enters FINISH.
- FINISH: product <= neg ? -acc (2*WIDTH-bit two's complement) : acc. done=1 for this cycle; next state IDLE.
- Arithmetic:
  - Magnitude of the most negative operand (-2^(WIDTH-1)) is 2^(WIDTH-1) and fits in WIDTH unsigned bits.
  - The accumulator never overflows 2*WIDTH bits in either mode.
  - A zero result in signed mode with neg=1 must produce 0 (negating 0 gives 0).
- start is ignored while busy=1, including the FINISH cycle. A start held high continuously relaunches on the first IDLE cycle after done.
- Operand inputs may change freely after acceptance without affecting the result.

## Timing
- Reset values: state=IDLE, busy=0, done=0, product=0, internal registers 0.
- Acceptance edge = cycle 0 (start=1 in IDLE).
- busy=1 in cycles 1..WIDTH+1.
- done=1 and new product visible in cycle WIDTH+1.
- Earliest next acceptance is cycle WIDTH+2.
- Fixed latency: WIDTH+1 cycles from acceptance to done, independent of operand values.
- rst=1 in any state:
  - Next cycle the block is in IDLE with all outputs at reset values; product is cleared.
  - The in-flight operation is discarded with no done pulse.
  - start asserted together with rst is ignored.
- done is never asserted in two consecutive cycles.
- product changes only on a done cycle or on reset.

## Test plan
- WIDTH=8, unsigned, 255 x 255 -> done exactly 9 cycles after acceptance, product=0xFE01; product still 0xFE01 20 cycles later.
- WIDTH=8, signed, -128 x -128 -> 0x4000. Signed -3 x 5 -> 0xFFF1. Signed -7 x 0 -> 0x0000.
- WIDTH=8, unsigned, 0x80 x 0x02 -> 0x0100. The same bits with signed_mode=1 -> 0xFF00.
- Start held high through two operations, with operands changed at cycle 3 -> first result uses the original operands. Second acceptance at cycle 10; done pulses at cycles 9 and 19 only.
- rst asserted at cycle 4 of an operation -> busy=0 and product=0 next cycle, no done pulse. A fresh start 2 cycles later yields a correct result 9 cycles after its acceptance.
- WIDTH=4 instance, unsigned 15 x 15 -> 0xE1 after 5 cycles. Signed -8 x 7 -> 0xC8.
